// File: rtl/core_types_pkg.sv
// Shared fetch-predictor types: return address stack sizing and redirect snapshot.
// RAS_UNDERFLOW_GUARD_EN (in ras) selects head behaviour on pop of an empty stack.
package core_types_pkg;

   localparam int RAS_ENTRIES      = 8;
   localparam int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES);
   localparam int RAS_TARGET_WIDTH = 31;
   localparam int RAS_COUNT_WIDTH  = RAS_INDEX_WIDTH + 1;

   typedef logic [RAS_INDEX_WIDTH-1:0]  ras_index_t;
   typedef logic [RAS_COUNT_WIDTH-1:0]  ras_count_t;
   typedef logic [RAS_TARGET_WIDTH-1:0] ras_target_t;

   typedef struct packed {
      ras_index_t index;
      ras_count_t count;
   } ras_snapshot_t;

   typedef enum logic [2:0] {
      RAS_OP_IDLE,
      RAS_OP_UPDATE,
      RAS_OP_SWAP,
      RAS_OP_PUSH,
      RAS_OP_POP
   } ras_op_e;

   localparam ras_count_t RAS_FULL = ras_count_t'(RAS_ENTRIES);

   function automatic ras_count_t ras_count_inc(input ras_count_t c);
      return (c == RAS_FULL) ? c : c + ras_count_t'(1);
   endfunction

endpackage

// File: rtl/ras.sv
// Speculative return address stack with snapshot restore on redirect.
// Define RAS_UNDERFLOW_GUARD_EN to freeze head when popping an empty stack.
module ras
   import core_types_pkg::*;
(
   input  logic                        CLK,
   input  logic                        nRST,
   input  logic                        push_valid,
   input  logic [RAS_TARGET_WIDTH-1:0] push_target,
   input  logic                        pop_valid,
   output logic [RAS_TARGET_WIDTH-1:0] ret_target,
   output logic                        ret_valid,
   output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
   output logic [RAS_COUNT_WIDTH-1:0]  ras_count,
   input  logic                        update_valid,
   input  logic [RAS_INDEX_WIDTH-1:0]  update_ras_index,
   input  logic [RAS_COUNT_WIDTH-1:0]  update_ras_count
);

   ras_target_t   stack [RAS_ENTRIES];
   ras_index_t    head;
   ras_index_t    head_next;
   ras_count_t    count;
   ras_count_t    count_next;
   ras_snapshot_t snap;
   ras_op_e       op;
   logic          wr_en;
   ras_index_t    wr_idx;
   ras_target_t   wr_data;

   assign snap = '{index: update_ras_index, count: update_ras_count};

   always_comb begin
      op = RAS_OP_IDLE;
      if (update_valid)
         op = RAS_OP_UPDATE;
      else if (push_valid && pop_valid)
         op = RAS_OP_SWAP;
      else if (push_valid)
         op = RAS_OP_PUSH;
      else if (pop_valid)
         op = RAS_OP_POP;
   end

   always_comb begin
      head_next  = head;
      count_next = count;
      wr_en      = 1'b0;
      wr_idx     = head;
      wr_data    = push_target;
      unique case (op)
         RAS_OP_UPDATE: begin
            head_next  = snap.index;
            count_next = snap.count;
         end
         RAS_OP_SWAP: begin
            wr_en = 1'b1;
         end
         RAS_OP_PUSH: begin
            head_next  = head + ras_index_t'(1);
            wr_en      = 1'b1;
            wr_idx     = head + ras_index_t'(1);
            count_next = ras_count_inc(count);
         end
         RAS_OP_POP: begin
            if (count != '0) begin
               head_next  = head - ras_index_t'(1);
               count_next = count - ras_count_t'(1);
            end else begin
`ifdef RAS_UNDERFLOW_GUARD_EN
               head_next = head;
`else
               // keep pointer in step with call chains that overflowed earlier
               head_next = head - ras_index_t'(1);
`endif
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head  <= '0;
         count <= '0;
      end else begin
         head  <= head_next;
         count <= count_next;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < RAS_ENTRIES; i++)
            stack[i] <= '0;
      end else if (wr_en) begin
         stack[wr_idx] <= wr_data;
      end
   end

   assign ret_target = stack[head];
   assign ret_valid  = (count != '0);
   assign ras_index  = head;
   assign ras_count  = count;

endmodule

// File: tb/tb_ras.sv
// Directed self-checking bench for the return address stack.
// Expectations follow RAS_UNDERFLOW_GUARD_EN when it is defined.
module tb_ras;
   import core_types_pkg::*;

   logic                        CLK;
   logic                        nRST;
   logic                        push_valid;
   logic [RAS_TARGET_WIDTH-1:0] push_target;
   logic                        pop_valid;
   logic [RAS_TARGET_WIDTH-1:0] ret_target;
   logic                        ret_valid;
   logic [RAS_INDEX_WIDTH-1:0]  ras_index;
   logic [RAS_COUNT_WIDTH-1:0]  ras_count;
   logic                        update_valid;
   logic [RAS_INDEX_WIDTH-1:0]  update_ras_index;
   logic [RAS_COUNT_WIDTH-1:0]  update_ras_count;

   int n_pass;
   int n_total;

   ras dut (
      .CLK              (CLK),
      .nRST             (nRST),
      .push_valid       (push_valid),
      .push_target      (push_target),
      .pop_valid        (pop_valid),
      .ret_target       (ret_target),
      .ret_valid        (ret_valid),
      .ras_index        (ras_index),
      .ras_count        (ras_count),
      .update_valid     (update_valid),
      .update_ras_index (update_ras_index),
      .update_ras_count (update_ras_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (update_valid)
         assert (update_ras_count <= RAS_COUNT_WIDTH'(RAS_ENTRIES))
         else $error("illegal update_ras_count %0d", update_ras_count);
   end

   task automatic drive(input logic pu, input logic [30:0] t, input logic po);
      push_valid  = pu;
      push_target = t;
      pop_valid   = po;
      @(posedge CLK);
      #1;
      push_valid  = 1'b0;
      pop_valid   = 1'b0;
      push_target = '0;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      #3;
      nRST = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      #3;
      n_total++;
      if (ret_valid !== 1'b0) $display("FAIL reset_ret_valid got %0h want 0", ret_valid);
      else n_pass++;
      n_total++;
      if (ras_index !== 3'd0) $display("FAIL reset_index got %0h want 0", ras_index);
      else n_pass++;
      n_total++;
      if (ras_count !== 4'd0) $display("FAIL reset_count got %0h want 0", ras_count);
      else n_pass++;
      nRST = 1'b1;
      @(posedge CLK);
      #1;
      n_total++;
      if (ret_target !== 31'h0) $display("FAIL reset_target got %0h want 0", ret_target);
      else n_pass++;
   endtask

   task automatic test_push_pop();
      do_reset();
      drive(1'b1, 31'h100, 1'b0);
      drive(1'b1, 31'h200, 1'b0);
      n_total++;
      if (ret_target !== 31'h200) $display("FAIL pp_top got %0h want 200", ret_target);
      else n_pass++;
      n_total++;
      if (ras_count !== 4'd2) $display("FAIL pp_count got %0d want 2", ras_count);
      else n_pass++;
      drive(1'b0, 31'h0, 1'b1);
      n_total++;
      if (ret_target !== 31'h100) $display("FAIL pp_pop_top got %0h want 100", ret_target);
      else n_pass++;
      n_total++;
      if (ras_index !== 3'd1) $display("FAIL pp_pop_index got %0d want 1", ras_index);
      else n_pass++;
      n_total++;
      if (ras_count !== 4'd1) $display("FAIL pp_pop_count got %0d want 1", ras_count);
      else n_pass++;
   endtask

   task automatic test_saturate();
      logic [30:0] exp;
      do_reset();
      for (int i = 1; i <= 10; i++)
         drive(1'b1, 31'(i), 1'b0);
      n_total++;
      if (ras_count !== 4'd8) $display("FAIL sat_count got %0d want 8", ras_count);
      else n_pass++;
      n_total++;
      if (ras_index !== 3'd2) $display("FAIL sat_index got %0d want 2", ras_index);
      else n_pass++;
      for (int k = 0; k < 8; k++) begin
         exp = 31'(10 - k);
         n_total++;
         if (ret_target !== exp)
            $display("FAIL sat_pop%0d got %0h want %0h", k, ret_target, exp);
         else n_pass++;
         drive(1'b0, 31'h0, 1'b1);
      end
      n_total++;
      if (ret_valid !== 1'b0) $display("FAIL sat_empty got %0d want 0", ret_valid);
      else n_pass++;
      n_total++;
      if (ras_index !== 3'd2) $display("FAIL sat_end_index got %0d want 2", ras_index);
      else n_pass++;
   endtask

   task automatic test_swap();
      do_reset();
      drive(1'b1, 31'h40, 1'b0);
      drive(1'b1, 31'h80, 1'b1);
      n_total++;
      if (ret_target !== 31'h80) $display("FAIL swap_top got %0h want 80", ret_target);
      else n_pass++;
      n_total++;
      if (ras_index !== 3'd1) $display("FAIL swap_index got %0d want 1", ras_index);
      else n_pass++;
      n_total++;
      if (ras_count !== 4'd1) $display("FAIL swap_count got %0d want 1", ras_count);
      else n_pass++;
   endtask

   task automatic test_update();
      do_reset();
      drive(1'b1, 31'h11, 1'b0);
      drive(1'b1, 31'h22, 1'b0);
      drive(1'b1, 31'h33, 1'b0);
      drive(1'b1, 31'h44, 1'b0);
      drive(1'b1, 31'h55, 1'b0);
      drive(1'b0, 31'h0, 1'b1);
      update_valid     = 1'b1;
      update_ras_index = 3'd3;
      update_ras_count = 4'd3;
      drive(1'b1, 31'h99, 1'b0);
      update_valid     = 1'b0;
      update_ras_index = '0;
      update_ras_count = '0;
      n_total++;
      if (ras_index !== 3'd3) $display("FAIL upd_index got %0d want 3", ras_index);
      else n_pass++;
      n_total++;
      if (ras_count !== 4'd3) $display("FAIL upd_count got %0d want 3", ras_count);
      else n_pass++;
      n_total++;
      if (ret_target !== 31'h33) $display("FAIL upd_top got %0h want 33", ret_target);
      else n_pass++;
   endtask

   task automatic test_underflow();
      logic [2:0] exp_idx;
`ifdef RAS_UNDERFLOW_GUARD_EN
      exp_idx = 3'd0;
`else
      exp_idx = 3'd7;
`endif
      do_reset();
      drive(1'b0, 31'h0, 1'b1);
      n_total++;
      if (ras_index !== exp_idx) $display("FAIL uf_index got %0d want %0d", ras_index, exp_idx);
      else n_pass++;
      n_total++;
      if (ras_count !== 4'd0) $display("FAIL uf_count got %0d want 0", ras_count);
      else n_pass++;
      n_total++;
      if (ret_valid !== 1'b0) $display("FAIL uf_valid got %0d want 0", ret_valid);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(1'b1, 31'h7, 1'b0);
      drive(1'b1, 31'h9, 1'b0);
      #2;
      nRST = 1'b0;
      #1;
      n_total++;
      if (ras_index !== 3'd0) $display("FAIL ar_index got %0d want 0", ras_index);
      else n_pass++;
      n_total++;
      if (ras_count !== 4'd0) $display("FAIL ar_count got %0d want 0", ras_count);
      else n_pass++;
      n_total++;
      if (ret_target !== 31'h0) $display("FAIL ar_top got %0h want 0", ret_target);
      else n_pass++;
      n_total++;
      if (ret_valid !== 1'b0) $display("FAIL ar_valid got %0d want 0", ret_valid);
      else n_pass++;
      nRST = 1'b1;
   endtask

   initial begin
      n_pass           = 0;
      n_total          = 0;
      nRST             = 1'b0;
      push_valid       = 1'b0;
      push_target      = '0;
      pop_valid        = 1'b0;
      update_valid     = 1'b0;
      update_ras_index = '0;
      update_ras_count = '0;
      @(posedge CLK);
      #1;
      test_reset();
      test_push_pop();
      test_saturate();
      test_swap();
      test_update();
      test_underflow();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
